mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Arbitrates one single-port memory between the instruction-fetch port (I) and the load/store port (D) of the core.
- Sequences each access: grant, issue, wait the fixed memory latency, capture, respond.
- One transaction in flight at a time. Sits between the core datapath and the shared ROM/data memory.

Parameters:
- MEM_LAT, 1: cycles from issue until mem_rdata is valid. Legal range is 1..15; 0 is unsupported.
- AW, 32: address width.
- DW, 32: data width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  AW  fetch address.
- if_gnt  out  1  one-cycle fetch grant.
- if_rvalid  out  1  one-cycle fetch data valid.
- if_rdata  out  DW  fetch data.
- d_req  in  1  load/store request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  load/store address.
- d_wdata  in  DW  store data.
- d_gnt  out  1  one-cycle load/store grant.
- d_rvalid  out  1  one-cycle completion; for a load, d_rdata is valid.
- d_rdata  out  DW  load data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after the mem_en cycle.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (reset=0), applied asynchronously:
  - state = IDLE, wait counter = 0, winner = none.
  - All outputs 0, including if_rdata and d_rdata.
  - Any in-flight transaction is dropped; no rvalid is issued for it after reset releases.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered or decoded from state plus captured registers.
- IDLE:
  - If neither request is high, stay in IDLE.
  - Otherwise select a winner and capture its addr, we and wdata at the clock edge; next state is ISSUE.
- ISSUE (exactly 1 cycle):
  - Winner's gnt = 1.
  - mem_en = 1; mem_we, mem_addr and mem_wdata driven from the captured registers.
  - Counter loaded with MEM_LAT; next state is WAIT.
- WAIT (MEM_LAT cycles):
  - mem_en = 0 and mem_we = 0.
  - Counter decrements each cycle.
  - On the cycle where counter = 1, mem_rdata is valid. For a read it is registered into the winner's rdata at that edge; next state is RESP.
- RESP (exactly 1 cycle):
  - Winner's rvalid = 1.
  - Next state is IDLE. The earliest next grant is evaluated in that IDLE cycle.
- Timing:
  - Request sampled in cycle 0 → ISSUE in cycle 1 → rvalid in cycle 2+MEM_LAT.
  - Port occupancy is MEM_LAT+3 cycles per access.
- Stores:
  - d_rvalid pulses as a completion acknowledge.
  - d_rdata is left unchanged.
  - A fetch is never a write: mem_we is forced to 0 when I wins.
- rdata hold: if_rdata and d_rdata hold their last captured value until the next read by the same port.
- Grants:
  - A requester may drop or change its request only after seeing gnt.
  - A request that changes before gnt is sampled afresh in IDLE.
  - A request still high in the RESP cycle is treated as a new request.
- Priority without the optional feature: fixed, D over I, on simultaneous requests. The data port must never wait behind fetch.
- The counter is 4 bits wide.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined:
  - Round-robin arbitration using a 1-bit last-winner register.
  - On simultaneous requests, the port that did not win last is granted.
  - last-winner resets to I, so D wins the first tie.
  - A lone requester always wins and updates last-winner.
- Undefined: fixed D-over-I priority as described in Behaviour; no last-winner register exists.

Test Plan:
- Fetch only, MEM_LAT=1, if_addr=0x00000010, mem_rdata=0x00500093 → if_gnt and mem_en in cycle 1 with mem_addr=0x10 and mem_we=0; if_rvalid in cycle 3 with if_rdata=0x00500093; busy in cycles 1–3.
- if_req and d_req (load, 0x200) both high in cycle 0, no macro → D granted in cycle 1, d_rvalid in cycle 3; I granted in cycle 5, if_rvalid in cycle 7.
- Store d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF → mem_en=1, mem_we=1, mem_wdata=0xDEADBEEF for exactly one cycle; d_rvalid pulse; d_rdata unchanged from its previous value.
- MEM_LAT=4, reset driven low during WAIT → all outputs 0 immediately, without waiting for a clock edge; after release, no rvalid and no mem_en until a new request.
- Both requests held high across 4 transactions → with ARB_RR_EN grant order is D, I, D, I; without it, D, D, D, D while d_req stays high.
- MEM_LAT=3, load → d_rvalid in exactly cycle 5; d_rdata equals the mem_rdata value presented in cycle 4.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, the load/store port and the memory side of mem_arbiter.
// The arbiter takes the slave view. The core and memory side takes the master view.
interface mem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch (I) and load/store (D), one access in flight.
// Defining ARB_RR_EN selects round-robin on ties. Otherwise D always beats I.
module mem_arbiter #(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  arb_io
);
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_e;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} own_e;

    state_e        state_q, state_d;
    own_e          own_q, own_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic          d_wins;

    logic          if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
    logic          if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic          mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          busy_q, busy_d;
`ifdef ARB_RR_EN
    logic          last_d_q, last_d_d;   // 1 = D won the previous arbitration
`endif

    // Winner selection, only consumed in IDLE
    always_comb begin
`ifdef ARB_RR_EN
        if (arb_io.d_req && arb_io.if_req) d_wins = ~last_d_q;
        else                               d_wins = arb_io.d_req;
`else
        d_wins = arb_io.d_req;
`endif
    end

    // Next state and next registered outputs
    always_comb begin
        state_d     = state_q;
        own_d       = own_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        if_gnt_d    = 1'b0;
        d_gnt_d     = 1'b0;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
`ifdef ARB_RR_EN
        last_d_d    = last_d_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (arb_io.if_req || arb_io.d_req) begin
                    state_d     = ST_ISSUE;
                    own_d       = d_wins ? OWN_D : OWN_I;
                    we_d        = d_wins & arb_io.d_we;
                    if_gnt_d    = ~d_wins;
                    d_gnt_d     = d_wins;
                    mem_en_d    = 1'b1;
                    mem_we_d    = d_wins & arb_io.d_we;
                    mem_addr_d  = d_wins ? arb_io.d_addr : arb_io.if_addr;
                    mem_wdata_d = d_wins ? arb_io.d_wdata : '0;
`ifdef ARB_RR_EN
                    last_d_d    = d_wins;
`endif
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = CW'(MEM_LAT);
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                // mem_rdata is valid on the last wait cycle
                if (cnt_q == CW'(1)) begin
                    state_d = ST_RESP;
                    if (own_q == OWN_I) begin
                        if_rdata_d  = arb_io.mem_rdata;
                        if_rvalid_d = 1'b1;
                    end
                    if (own_q == OWN_D) begin
                        if (!we_q) d_rdata_d = arb_io.mem_rdata;
                        d_rvalid_d = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                own_d   = OWN_NONE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            own_q       <= OWN_NONE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
`ifdef ARB_RR_EN
            last_d_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            own_q       <= own_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
`ifdef ARB_RR_EN
            last_d_q    <= last_d_d;
`endif
        end
    end

    assign arb_io.if_gnt    = if_gnt_q;
    assign arb_io.d_gnt     = d_gnt_q;
    assign arb_io.if_rvalid = if_rvalid_q;
    assign arb_io.d_rvalid  = d_rvalid_q;
    assign arb_io.if_rdata  = if_rdata_q;
    assign arb_io.d_rdata   = d_rdata_q;
    assign arb_io.mem_en    = mem_en_q;
    assign arb_io.mem_we    = mem_we_q;
    assign arb_io.mem_addr  = mem_addr_q;
    assign arb_io.mem_wdata = mem_wdata_q;
    assign arb_io.busy      = busy_q;
endmodule
